rv32im_writeback: RTL and testbench
===================================

# rv32im_writeback

Writeback stage for the rv32im core: collects completed results from the ALU, the load path and the multi-cycle mul/div unit, and presents one registered write per cycle to the register file's write port (write, rd address, data). It formats raw load words (byte/half extraction, sign/zero extension), arbitrates colliding results with a one-entry holding register, and keeps a register busy scoreboard the decoder uses for RAW/WAW hazard stalls.

## Interface
- XLEN, 32, datapath width
- REG_BITS, 5, register address width
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- alu_valid_i / alu_rd_i / alu_data_i  in  1 / REG_BITS / XLEN  single-cycle ALU result; no backpressure
- load_valid_i / load_rd_i / load_word_i  in  1 / REG_BITS / XLEN  raw aligned memory word
- load_funct3_i / load_offset_i  in  3 / 2  load type, byte offset addr[1:0]
- md_valid_i / md_rd_i / md_data_i  in  1 / REG_BITS / XLEN  mul/div result
- md_ready_o  out  1  mul/div result accepted this cycle
- stall_o  out  1  holding register occupied; upstream must not present alu/load
- issue_i / issue_rd_i  in  1 / REG_BITS  instruction issued that will write issue_rd_i
- rs1_addr_i / rs2_addr_i  in  REG_BITS  decoder source addresses
- busy_rs1_o / busy_rs2_o / busy_rd_o  out  1  rs1 / rs2 / issue_rd_i pending write (combinational from scoreboard)
- reg_write_o / reg_addr_o / reg_data_o  out  1 / REG_BITS / XLEN  registered register-file write

## Operation
- Load format: shift load_word_i right by 8*offset; LB 000 sign-extend [7:0]; LH 001 sign-extend [15:0]; LW 010 full word; LBU 100 / LHU 101 zero-extend. Other funct3: data 0, write still committed. LH/LHU with offset 3 undefined (alignment handled upstream).
- Priority per cycle: held entry > load > ALU > mul/div.
- Load and ALU same cycle, hold empty: load commits, ALU into hold; stall_o high from next cycle.
- Hold occupied: hold commits; any load/ALU presented the same cycle (protocol violation) is dropped.
- md_ready_o = md_valid_i & no hold & no load & no ALU this cycle; mul/div keeps result stable until accepted.
- rd = 0: result consumed normally, reg_write_o stays 0, no scoreboard change.
- Scoreboard: REG_BITS-addressed busy bit per register. issue_i with rd≠0 sets bit; committed write clears it. Same-edge set and clear of same rd: set wins. Bit 0 always 0. Issuing to a busy rd is a protocol violation (decoder stalls on busy_rd_o).

## Timing
- Result accepted in cycle N → reg_write_o/reg_addr_o/reg_data_o valid in N+1 for exactly one cycle; scoreboard bit clears on the edge ending N+1 (same edge the register file writes).
- Issue in cycle N → busy visible from N+1.
- stall_o is registered: high the cycle after the collision, low the cycle after the hold commits.
- Reset: reg_write_o 0, reg_addr_o 0, reg_data_o 0, stall_o 0, md_ready_o 0, hold empty, all busy bits 0. Reset mid-operation discards hold and pending writes.

## Configuration
- RV32IM_WB_SCOREBOARD_EN: defined → scoreboard and busy_* outputs as above. Undefined → no scoreboard state; busy_rs1_o, busy_rs2_o, busy_rd_o tied 0; issue_i ignored; writeback path unchanged.

## Test plan
- LB funct3 000, offset 2, word 0x12_80_34_56 → reg_data_o 0xFFFFFF80 in N+1; LHU offset 2 same word → 0x00001280.
- ALU rd=5 data 0xA and load rd=6 same cycle → N+1 write x6, N+2 write x5, stall_o high exactly in N+1.
- md_valid_i with ALU valid → md_ready_o 0; ALU idle next cycle → md_ready_o 1, write one cycle later.
- ALU result rd=0 data 0xDEAD → reg_write_o stays 0.
- issue rd=7 → busy_rs1_o with rs1=7 high next cycle; ALU write rd=7 → busy low the cycle after reg_write_o; issue rd=7 on the clearing edge → stays busy.
- rst_ni low while hold occupied and busy bits set → all outputs 0 immediately, no write after release.

Source files
------------

// File: rtl/rv32im_writeback_if.sv
// Result bus between the execution units and the writeback stage.
// Fields keep the writeback-side _i/_o naming so the slave modport reads
// like the block's own port list.
interface rv32im_writeback_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
);
  logic                alu_valid_i;
  logic [REG_BITS-1:0] alu_rd_i;
  logic [XLEN-1:0]     alu_data_i;
  logic                load_valid_i;
  logic [REG_BITS-1:0] load_rd_i;
  logic [XLEN-1:0]     load_word_i;
  logic [2:0]          load_funct3_i;
  logic [1:0]          load_offset_i;
  logic                md_valid_i;
  logic [REG_BITS-1:0] md_rd_i;
  logic [XLEN-1:0]     md_data_i;
  logic                md_ready_o;
  logic                stall_o;
  logic                reg_write_o;
  logic [REG_BITS-1:0] reg_addr_o;
  logic [XLEN-1:0]     reg_data_o;

  // Execution units / register file side
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
           load_valid_i, load_rd_i, load_word_i, load_funct3_i, load_offset_i,
           md_valid_i, md_rd_i, md_data_i,
    input  md_ready_o, stall_o, reg_write_o, reg_addr_o, reg_data_o
  );

  // Writeback stage side
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
           load_valid_i, load_rd_i, load_word_i, load_funct3_i, load_offset_i,
           md_valid_i, md_rd_i, md_data_i,
    output md_ready_o, stall_o, reg_write_o, reg_addr_o, reg_data_o
  );
endinterface

// File: rtl/rv32im_writeback.sv
// rv32im writeback stage: load formatting, result arbitration with a
// one-entry holding register, registered register-file write port and an
// optional register busy scoreboard.
// Optional feature: define RV32IM_WB_SCOREBOARD_EN to build the scoreboard;
// without it the busy_* outputs are tied low and issue_i is ignored.
module rv32im_writeback #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rv32im_writeback_if.slave   wb,
  input  logic                issue_i,
  input  logic [REG_BITS-1:0] issue_rd_i,
  input  logic [REG_BITS-1:0] rs1_addr_i,
  input  logic [REG_BITS-1:0] rs2_addr_i,
  output logic                busy_rs1_o,
  output logic                busy_rs2_o,
  output logic                busy_rd_o
);
  localparam int NREGS = 1 << REG_BITS;

  logic [XLEN-1:0]     ld_shift;
  logic [XLEN-1:0]     ld_data;

  logic                hold_vld_q, hold_vld_d;
  logic [REG_BITS-1:0] hold_rd_q, hold_rd_d;
  logic [XLEN-1:0]     hold_data_q, hold_data_d;

  logic                commit;
  logic [REG_BITS-1:0] commit_rd;
  logic [XLEN-1:0]     commit_data;
  logic                md_take;

  logic                wr_q;
  logic [REG_BITS-1:0] addr_q;
  logic [XLEN-1:0]     data_q;

  // Load formatting: bring the addressed byte/half to bit 0, then extend
  always_comb begin
    ld_shift = wb.load_word_i >> {wb.load_offset_i, 3'b000};
    case (wb.load_funct3_i)
      3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_data = ld_shift;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = '0;  // unknown load type still commits, as zero
    endcase
  end

  // Arbitration: hold > load > ALU > mul/div. A held entry drops any
  // load/ALU presented alongside it (upstream should have seen stall_o).
  always_comb begin
    commit      = 1'b0;
    commit_rd   = '0;
    commit_data = '0;
    md_take     = 1'b0;
    hold_vld_d  = hold_vld_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (hold_vld_q) begin
      commit      = 1'b1;
      commit_rd   = hold_rd_q;
      commit_data = hold_data_q;
      hold_vld_d  = 1'b0;
    end else if (wb.load_valid_i) begin
      commit      = 1'b1;
      commit_rd   = wb.load_rd_i;
      commit_data = ld_data;
      if (wb.alu_valid_i) begin
        hold_vld_d  = 1'b1;
        hold_rd_d   = wb.alu_rd_i;
        hold_data_d = wb.alu_data_i;
      end
    end else if (wb.alu_valid_i) begin
      commit      = 1'b1;
      commit_rd   = wb.alu_rd_i;
      commit_data = wb.alu_data_i;
    end else if (wb.md_valid_i) begin
      commit      = 1'b1;
      commit_rd   = wb.md_rd_i;
      commit_data = wb.md_data_i;
      md_take     = 1'b1;
    end
  end

  assign wb.md_ready_o = md_take;
  assign wb.stall_o    = hold_vld_q;

  // Holding register for the ALU result displaced by a load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_vld_q  <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Registered write port; x0 results are consumed without a write strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= commit && (commit_rd != '0);
      if (commit) begin
        addr_q <= commit_rd;
        data_q <= commit_data;
      end
    end
  end

  assign wb.reg_write_o = wr_q;
  assign wb.reg_addr_o  = addr_q;
  assign wb.reg_data_o  = data_q;

`ifdef RV32IM_WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d, set_vec, clr_vec;

  // Busy bits: cleared by the write currently on the port, set by issue;
  // set wins so a re-issue on the clearing edge stays busy
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_i && (issue_rd_i != '0)) set_vec[issue_rd_i] = 1'b1;
    if (wr_q) clr_vec[addr_q] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_rs1_o = busy_q[rs1_addr_i];
  assign busy_rs2_o = busy_q[rs2_addr_i];
  assign busy_rd_o  = busy_q[issue_rd_i];
`else
  logic unused_sb;
  assign unused_sb  = ^{issue_i, issue_rd_i, rs1_addr_i, rs2_addr_i, NREGS[0]};
  assign busy_rs1_o = 1'b0;
  assign busy_rs2_o = 1'b0;
  assign busy_rd_o  = 1'b0;
`endif
endmodule

// File: tb/tb_rv32im_writeback.sv
// Directed bench for rv32im_writeback. Expected register writes go into a
// queue at stimulus time; a negedge monitor pops and compares every write
// the DUT presents, including the cycle it should appear in.
module tb_rv32im_writeback;
  localparam int XLEN = 32;
  localparam int RB   = 5;
`ifdef RV32IM_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue;
  logic [RB-1:0] issue_rd, rs1, rs2;
  logic          busy_rs1, busy_rs2, busy_rd;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    logic [RB-1:0]   rd;
    logic [XLEN-1:0] data;
    int              cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;
  ld_vec_t lv[7];

  rv32im_writeback_if #(.XLEN(XLEN), .REG_BITS(RB)) wbif ();

  rv32im_writeback #(.XLEN(XLEN), .REG_BITS(RB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wb         (wbif.slave),
    .issue_i    (issue),
    .issue_rd_i (issue_rd),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .busy_rs1_o (busy_rs1),
    .busy_rs2_o (busy_rs2),
    .busy_rd_o  (busy_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n && wbif.reg_write_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got write x%0d=0x%08h at cycle %0d, expected none",
                 wbif.reg_addr_o, wbif.reg_data_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wbif.reg_addr_o !== e.rd || wbif.reg_data_o !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL wr_match: got x%0d=0x%08h at cycle %0d, expected x%0d=0x%08h at cycle %0d",
                   wbif.reg_addr_o, wbif.reg_data_o, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [RB-1:0] rd, input logic [31:0] d, input int c);
    exp_t e;
    e.rd = rd; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    wbif.alu_valid_i  = 1'b0; wbif.alu_rd_i  = '0; wbif.alu_data_i  = '0;
    wbif.load_valid_i = 1'b0; wbif.load_rd_i = '0; wbif.load_word_i = '0;
    wbif.load_funct3_i = 3'b010; wbif.load_offset_i = 2'd0;
    wbif.md_valid_i   = 1'b0; wbif.md_rd_i   = '0; wbif.md_data_i   = '0;
    issue = 1'b0; issue_rd = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"},    {31'd0, wbif.reg_write_o}, 32'd0);
    chk({tag, "_addr"},  {27'd0, wbif.reg_addr_o},  32'd0);
    chk({tag, "_data"},  wbif.reg_data_o,           32'd0);
    chk({tag, "_stall"}, {31'd0, wbif.stall_o},     32'd0);
    chk({tag, "_mdrdy"}, {31'd0, wbif.md_ready_o},  32'd0);
    chk({tag, "_busy"},  {29'd0, busy_rs1, busy_rs2, busy_rd}, 32'd0);
  endtask

  initial begin
    lv[0] = '{3'b000, 2'd2, 32'h12803456, 32'hFFFFFF80};  // LB sign
    lv[1] = '{3'b101, 2'd2, 32'h12803456, 32'h00001280};  // LHU
    lv[2] = '{3'b000, 2'd0, 32'h12803456, 32'h00000056};  // LB positive
    lv[3] = '{3'b001, 2'd0, 32'h00008001, 32'hFFFF8001};  // LH sign
    lv[4] = '{3'b010, 2'd0, 32'hCAFEBABE, 32'hCAFEBABE};  // LW
    lv[5] = '{3'b100, 2'd3, 32'h12803456, 32'h00000012};  // LBU top byte
    lv[6] = '{3'b011, 2'd1, 32'hFFFFFFFF, 32'h00000000};  // bad funct3

    idle_inputs();
    rs1 = 5'd7; rs2 = 5'd7;
    repeat (3) step();
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    step();

    // Load formatting, back to back
    for (int i = 0; i < 7; i++) begin
      wbif.load_valid_i  = 1'b1;
      wbif.load_rd_i     = RB'(16 + i);
      wbif.load_funct3_i = lv[i].f3;
      wbif.load_offset_i = lv[i].off;
      wbif.load_word_i   = lv[i].word;
      push(RB'(16 + i), lv[i].exp, cyc + 1);
      step();
    end
    idle_inputs();
    step();

    // Load/ALU collision, then a dropped ALU result while the hold is full
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd5; wbif.alu_data_i = 32'hA;
    wbif.load_valid_i = 1'b1; wbif.load_rd_i = 5'd6; wbif.load_word_i = 32'h66;
    push(5'd6, 32'h66, cyc + 1);
    push(5'd5, 32'hA, cyc + 2);
    chk("coll_stall_before", {31'd0, wbif.stall_o}, 32'd0);
    step();
    chk("coll_stall_n1", {31'd0, wbif.stall_o}, 32'd1);
    idle_inputs();
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd8; wbif.alu_data_i = 32'h88;
    step();
    idle_inputs();
    chk("coll_stall_n2", {31'd0, wbif.stall_o}, 32'd0);
    step();

    // mul/div waits behind the ALU
    wbif.md_valid_i = 1'b1; wbif.md_rd_i = 5'd10; wbif.md_data_i = 32'h1234;
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd11; wbif.alu_data_i = 32'hB;
    push(5'd11, 32'hB, cyc + 1);
    #1 chk("md_ready_blocked", {31'd0, wbif.md_ready_o}, 32'd0);
    step();
    wbif.alu_valid_i = 1'b0;
    #1 chk("md_ready_free", {31'd0, wbif.md_ready_o}, 32'd1);
    push(5'd10, 32'h1234, cyc + 1);
    step();
    wbif.md_valid_i = 1'b0;
    step();

    // x0 result: consumed, no write strobe
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd0; wbif.alu_data_i = 32'hDEAD;
    step();
    idle_inputs();
    chk("x0_no_write", {31'd0, wbif.reg_write_o}, 32'd0);
    step();

    // Scoreboard: set on issue, clear after write
    issue = 1'b1; issue_rd = 5'd7;
    step();
    issue = 1'b0;
    chk("sb_busy_rs1", {31'd0, busy_rs1}, {31'd0, SB});
    chk("sb_busy_rs2", {31'd0, busy_rs2}, {31'd0, SB});
    chk("sb_busy_rd",  {31'd0, busy_rd},  {31'd0, SB});
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd7; wbif.alu_data_i = 32'h77;
    push(5'd7, 32'h77, cyc + 1);
    step();
    idle_inputs();
    chk("sb_busy_during_wr", {31'd0, busy_rs1}, {31'd0, SB});
    step();
    chk("sb_cleared", {31'd0, busy_rs1}, 32'd0);

    // Re-issue on the clearing edge keeps the bit set
    issue = 1'b1; issue_rd = 5'd7;
    step();
    issue = 1'b0;
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd7; wbif.alu_data_i = 32'h78;
    push(5'd7, 32'h78, cyc + 1);
    step();
    idle_inputs();
    issue = 1'b1; issue_rd = 5'd7;
    step();
    issue = 1'b0;
    chk("sb_set_wins", {31'd0, busy_rs1}, {31'd0, SB});
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd7; wbif.alu_data_i = 32'h79;
    push(5'd7, 32'h79, cyc + 1);
    step();
    idle_inputs();
    step();
    chk("sb_final_clear", {31'd0, busy_rs1}, 32'd0);
    rs1 = 5'd0;
    chk("sb_x0_never_busy", {31'd0, busy_rs1}, 32'd0);

    // Reset while the hold is occupied and a busy bit is set
    rs1 = 5'd12;
    issue = 1'b1; issue_rd = 5'd12;
    wbif.alu_valid_i = 1'b1; wbif.alu_rd_i = 5'd13; wbif.alu_data_i = 32'h1313;
    wbif.load_valid_i = 1'b1; wbif.load_rd_i = 5'd14; wbif.load_word_i = 32'h1414;
    push(5'd14, 32'h1414, cyc + 1);
    step();
    idle_inputs();
    chk("rst_hold_full", {31'd0, wbif.stall_o}, 32'd1);
    chk("rst_busy_set", {31'd0, busy_rs1}, {31'd0, SB});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending writes, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
